// File: rtl/sdram_arbiter.sv
// Two-port arbiter/sequencer sharing one sdram_controller between the CPU path (port 0) and a DMA master (port 1).
// Latency: write ack in the 5th cycle after req is sampled (busy high 1 cycle); read ack 4 cycles + controller rd_ready delay.
// Backpressure: requester holds req until its ack; controller busy stalls the strobe; a watchdog aborts hung accesses with err.
module sdram_arbiter #(
  parameter int ADDR_W         = 25,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT        = 255,
  parameter int FIXED_PRIORITY = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic              p0_err,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic              p1_err,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_enable,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_enable,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_ready,
  input  logic              busy,
  output logic [1:0]        grant
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_ACC  = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_RESP      = 3'd4
  } state_t;

  localparam logic [16:0] TIMEOUT_L = 17'(TIMEOUT);

  state_t            state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic              last_grant_q, last_grant_d;  // 1 = port 1 was granted last
  logic              we_q, we_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
  logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;
  logic [15:0]       wdog_q, wdog_d;
  logic              p0_ack_q, p0_ack_d;
  logic              p1_ack_q, p1_ack_d;
  logic              p0_err_q, p0_err_d;
  logic              p1_err_q, p1_err_d;

  logic [16:0]       wdog_inc;
  logic              timed_out;
  logic              issue_ok;
  logic              sel_p1;
  logic              go_resp;
  logic              resp_err;
  logic              capture;

  // Watchdog fires on the cycle its count would reach TIMEOUT, so the ack lands
  // exactly TIMEOUT cycles after ISSUE was entered.
  assign wdog_inc  = {1'b0, wdog_q} + 17'd1;
  assign timed_out = (wdog_inc >= TIMEOUT_L);

  // The strobe must be seen by the controller in the ISSUE cycle itself, and only
  // while it is not busy, so it is decoded from the registered state and busy.
  assign issue_ok  = (state_q == S_ISSUE) && !busy;
  assign wr_enable = issue_ok && we_q;
  assign rd_enable = issue_ok && !we_q;

  assign wr_addr  = wr_addr_q;
  assign rd_addr  = rd_addr_q;
  assign wr_data  = wr_data_q;
  assign grant    = grant_q;
  assign p0_ack   = p0_ack_q;
  assign p1_ack   = p1_ack_q;
  assign p0_err   = p0_err_q;
  assign p1_err   = p1_err_q;
  assign p0_rdata = p0_rdata_q;
  assign p1_rdata = p1_rdata_q;

  // Next-state logic: arbitration, access sequencing, completion and watchdog abort.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    wr_addr_d    = wr_addr_q;
    rd_addr_d    = rd_addr_q;
    wr_data_d    = wr_data_q;
    p0_rdata_d   = p0_rdata_q;
    p1_rdata_d   = p1_rdata_q;
    wdog_d       = wdog_q;
    sel_p1       = 1'b0;
    go_resp      = 1'b0;
    resp_err     = 1'b0;
    capture      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (p0_req || p1_req) begin
          if (p0_req && p1_req) begin
            sel_p1 = (FIXED_PRIORITY == 0) ? !last_grant_q : 1'b0;
          end else begin
            sel_p1 = p1_req;
          end
          grant_d      = sel_p1 ? 2'b10 : 2'b01;
          last_grant_d = sel_p1;
          we_d         = sel_p1 ? p1_we : p0_we;
          wr_addr_d    = sel_p1 ? p1_addr : p0_addr;
          rd_addr_d    = sel_p1 ? p1_addr : p0_addr;
          wr_data_d    = sel_p1 ? p1_wdata : p0_wdata;
          wdog_d       = '0;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wdog_d = wdog_inc[15:0];
        if (!busy) begin
          state_d = S_WAIT_ACC;
        end else if (timed_out) begin
          go_resp  = 1'b1;
          resp_err = 1'b1;
        end
      end
      S_WAIT_ACC: begin
        wdog_d = wdog_inc[15:0];
        if (!we_q && rd_ready) begin
          capture = 1'b1;
          go_resp = 1'b1;
        end else if (busy) begin
          state_d = S_WAIT_DONE;
        end else if (timed_out) begin
          go_resp  = 1'b1;
          resp_err = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        wdog_d = wdog_inc[15:0];
        if (we_q ? !busy : rd_ready) begin
          capture = !we_q;
          go_resp = 1'b1;
        end else if (timed_out) begin
          go_resp  = 1'b1;
          resp_err = 1'b1;
        end
      end
      S_RESP: begin
        grant_d = 2'b00;
        state_d = S_IDLE;
      end
      default: begin
        grant_d = 2'b00;
        state_d = S_IDLE;
      end
    endcase

    if (go_resp) begin
      state_d = S_RESP;
    end
    if (capture && grant_q[0]) begin
      p0_rdata_d = rd_data;
    end
    if (capture && grant_q[1]) begin
      p1_rdata_d = rd_data;
    end

    p0_ack_d = go_resp && grant_q[0];
    p1_ack_d = go_resp && grant_q[1];
    p0_err_d = go_resp && resp_err && grant_q[0];
    p1_err_d = go_resp && resp_err && grant_q[1];
  end

  // State and output registers; reset abandons any access in flight without an ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      grant_q      <= 2'b00;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      wr_data_q    <= '0;
      p0_rdata_q   <= '0;
      p1_rdata_q   <= '0;
      wdog_q       <= '0;
      p0_ack_q     <= 1'b0;
      p1_ack_q     <= 1'b0;
      p0_err_q     <= 1'b0;
      p1_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      wr_addr_q    <= wr_addr_d;
      rd_addr_q    <= rd_addr_d;
      wr_data_q    <= wr_data_d;
      p0_rdata_q   <= p0_rdata_d;
      p1_rdata_q   <= p1_rdata_d;
      wdog_q       <= wdog_d;
      p0_ack_q     <= p0_ack_d;
      p1_ack_q     <= p1_ack_d;
      p0_err_q     <= p0_err_d;
      p1_err_q     <= p1_err_d;
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: round-robin instance (TIMEOUT=20) plus a fixed-priority instance.
// Controller behaviour is driven cycle by cycle from the test tasks; outputs sampled 2 time units after each edge.
// Each task checks its own scenario inline and the run ends with a single summary line.
module tb_sdram_arbiter;
  localparam int AW = 25;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          p0_req = 1'b0, p0_we = 1'b0;
  logic [AW-1:0] p0_addr = '0;
  logic [DW-1:0] p0_wdata = '0;
  logic          p1_req = 1'b0, p1_we = 1'b0;
  logic [AW-1:0] p1_addr = '0;
  logic [DW-1:0] p1_wdata = '0;
  logic          busy = 1'b0, rd_ready = 1'b0;
  logic [DW-1:0] rd_data = '0;

  logic          p0_ack, p1_ack, p0_err, p1_err;
  logic [DW-1:0] p0_rdata, p1_rdata, wr_data;
  logic [AW-1:0] wr_addr, rd_addr;
  logic          wr_enable, rd_enable;
  logic [1:0]    grant;

  logic          p0_ack_b, p1_ack_b, p0_err_b, p1_err_b;
  logic [DW-1:0] p0_rdata_b, p1_rdata_b, wr_data_b;
  logic [AW-1:0] wr_addr_b, rd_addr_b;
  logic          wr_enable_b, rd_enable_b;
  logic [1:0]    grant_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sdram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(20), .FIXED_PRIORITY(0)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_enable(wr_enable),
    .rd_addr(rd_addr), .rd_enable(rd_enable),
    .rd_data(rd_data), .rd_ready(rd_ready), .busy(busy), .grant(grant)
  );

  sdram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(255), .FIXED_PRIORITY(1)) dut_fp (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack_b), .p0_err(p0_err_b), .p0_rdata(p0_rdata_b),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack_b), .p1_err(p1_err_b), .p1_rdata(p1_rdata_b),
    .wr_addr(wr_addr_b), .wr_data(wr_data_b), .wr_enable(wr_enable_b),
    .rd_addr(rd_addr_b), .rd_enable(rd_enable_b),
    .rd_data(rd_data), .rd_ready(rd_ready), .busy(busy), .grant(grant_b)
  );

  // Advance to 1 time unit after the next rising edge; inputs are driven there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (grant !== 2'b00) begin failures++; $display("FAIL rst_grant got=%b exp=00", grant); end
    checks++;
    if ({p0_ack, p1_ack, p0_err, p1_err} !== 4'b0000) begin
      failures++; $display("FAIL rst_ack_err got=%b exp=0000", {p0_ack, p1_ack, p0_err, p1_err});
    end
    checks++;
    if ({wr_enable, rd_enable} !== 2'b00) begin failures++; $display("FAIL rst_strobes got=%b exp=00", {wr_enable, rd_enable}); end
    checks++;
    if (wr_addr !== '0 || rd_addr !== '0 || wr_data !== '0) begin
      failures++; $display("FAIL rst_ctrl_bus got=%h/%h/%h exp=0/0/0", wr_addr, rd_addr, wr_data);
    end
    checks++;
    if (p0_rdata !== '0 || p1_rdata !== '0) begin
      failures++; $display("FAIL rst_rdata got=%h/%h exp=0/0", p0_rdata, p1_rdata);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (grant !== 2'b00) begin failures++; $display("FAIL idle_grant got=%b exp=00", grant); end
  endtask

  task automatic test_single_write();
    int pulses, acks, ack_cyc;
    pulses = 0; acks = 0; ack_cyc = -1;
    tick();
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 25'h0001234; p0_wdata = 16'hBEEF;
    for (int k = 2; k <= 10; k++) begin
      tick();
      busy = (k >= 3 && k <= 5);
      #1;
      checks++;
      if ((wr_enable || rd_enable) && busy) begin failures++; $display("FAIL wr_strobe_while_busy cycle=%0d", k); end
      if (k == 2) begin
        checks++;
        if (grant !== 2'b01) begin failures++; $display("FAIL wr_grant got=%b exp=01", grant); end
      end
      if (wr_enable) begin
        pulses++;
        checks++;
        if (wr_addr !== 25'h0001234 || wr_data !== 16'hBEEF) begin
          failures++; $display("FAIL wr_bus got=%h/%h exp=0001234/beef", wr_addr, wr_data);
        end
      end
      if (p0_ack) begin
        acks++;
        if (ack_cyc < 0) begin
          ack_cyc = k;
          p0_req = 1'b0;
          checks++;
          if (p0_err !== 1'b0) begin failures++; $display("FAIL wr_err got=%b exp=0", p0_err); end
        end
      end
    end
    checks++;
    if (pulses != 1) begin failures++; $display("FAIL wr_pulses got=%0d exp=1", pulses); end
    checks++;
    if (acks != 1) begin failures++; $display("FAIL wr_ack_count got=%0d exp=1", acks); end
    checks++;
    if (ack_cyc != 7) begin failures++; $display("FAIL wr_ack_cycle got=%0d exp=7", ack_cyc); end
  endtask

  task automatic test_single_read();
    int pulses, ack_cyc;
    pulses = 0; ack_cyc = -1;
    tick();
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 25'h00000FF; p1_wdata = 16'h0000;
    for (int k = 2; k <= 12; k++) begin
      tick();
      busy     = (k >= 3 && k <= 7);
      rd_ready = (k == 8);
      rd_data  = (k == 8) ? 16'hCAFE : 16'h0000;
      #1;
      if (rd_enable) begin
        pulses++;
        checks++;
        if (rd_addr !== 25'h00000FF) begin failures++; $display("FAIL rd_addr got=%h exp=00000ff", rd_addr); end
      end
      if (p1_ack && ack_cyc < 0) begin
        ack_cyc = k;
        p1_req = 1'b0;
        checks++;
        if (p1_rdata !== 16'hCAFE || p1_err !== 1'b0) begin
          failures++; $display("FAIL rd_ack_data got=%h err=%b exp=cafe err=0", p1_rdata, p1_err);
        end
      end
    end
    rd_ready = 1'b0;
    checks++;
    if (pulses != 1) begin failures++; $display("FAIL rd_pulses got=%0d exp=1", pulses); end
    checks++;
    if (ack_cyc != 9) begin failures++; $display("FAIL rd_ack_cycle got=%0d exp=9", ack_cyc); end
    checks++;
    if (p1_rdata !== 16'hCAFE) begin failures++; $display("FAIL rd_hold got=%h exp=cafe", p1_rdata); end
    checks++;
    if (p0_rdata !== 16'h0000) begin failures++; $display("FAIL rd_other_port got=%h exp=0000", p0_rdata); end
  endtask

  task automatic test_round_robin();
    int  ord0 [4];
    int  ord1 [4];
    int  ack_t [4];
    int  n0, n1;
    logic strobe_prev;
    n0 = 0; n1 = 0; strobe_prev = 1'b0;
    tick();
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 25'h0000100; p0_wdata = 16'h0A0A;
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 25'h0000200; p1_wdata = 16'h0B0B;
    for (int k = 2; k <= 40 && (n0 < 4 || n1 < 4); k++) begin
      tick();
      busy = strobe_prev;
      #1;
      strobe_prev = wr_enable;
      if (wr_enable) begin
        checks++;
        if (grant == 2'b10 ? (wr_addr !== 25'h0000200 || wr_data !== 16'h0B0B)
                           : (wr_addr !== 25'h0000100 || wr_data !== 16'h0A0A)) begin
          failures++; $display("FAIL rr_bus grant=%b got=%h/%h", grant, wr_addr, wr_data);
        end
      end
      if (p0_ack || p1_ack) begin
        if (n0 < 4) begin
          ord0[n0]  = p1_ack ? 1 : 0;
          ack_t[n0] = k;
        end
        n0++;
        if (n0 == 4) begin
          p0_req = 1'b0;
          p1_req = 1'b0;
        end
      end
      if (p0_ack_b || p1_ack_b) begin
        if (n1 < 4) ord1[n1] = p1_ack_b ? 1 : 0;
        n1++;
      end
    end
    busy = 1'b0;
    checks++;
    if (n0 != 4 || n1 != 4) begin failures++; $display("FAIL rr_ack_count got=%0d/%0d exp=4/4", n0, n1); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i < n0 && ord0[i] != (i % 2)) begin failures++; $display("FAIL rr_order idx=%0d got=p%0d exp=p%0d", i, ord0[i], i % 2); end
      checks++;
      if (i < n1 && ord1[i] != 0) begin failures++; $display("FAIL fp_order idx=%0d got=p%0d exp=p0", i, ord1[i]); end
      checks++;
      if (i < n0 && ack_t[i] != 5 + 5 * i) begin failures++; $display("FAIL rr_ack_cycle idx=%0d got=%0d exp=%0d", i, ack_t[i], 5 + 5 * i); end
    end
  endtask

  task automatic test_busy_stall();
    int pulses, strobe_cyc, ack_cyc;
    pulses = 0; strobe_cyc = -1; ack_cyc = -1;
    tick();
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 25'h0ABCDEF; p0_wdata = 16'h1357;
    for (int k = 2; k <= 20; k++) begin
      tick();
      busy = (k >= 2 && k <= 11) || (k == 13);
      #1;
      checks++;
      if ((wr_enable || rd_enable) && busy) begin failures++; $display("FAIL stall_strobe_while_busy cycle=%0d", k); end
      if (wr_enable) begin
        pulses++;
        if (strobe_cyc < 0) strobe_cyc = k;
      end
      if (p0_ack && ack_cyc < 0) begin
        ack_cyc = k;
        p0_req = 1'b0;
      end
    end
    busy = 1'b0;
    checks++;
    if (pulses != 1) begin failures++; $display("FAIL stall_pulses got=%0d exp=1", pulses); end
    checks++;
    if (strobe_cyc != 12) begin failures++; $display("FAIL stall_strobe_cycle got=%0d exp=12", strobe_cyc); end
    checks++;
    if (ack_cyc != 15) begin failures++; $display("FAIL stall_ack_cycle got=%0d exp=15", ack_cyc); end
  endtask

  task automatic test_timeout();
    int pulses, ack_cyc;
    logic strobe_prev;
    // Fast read that completes straight out of WAIT_ACC, giving p0_rdata a known value.
    ack_cyc = -1;
    tick();
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 25'h0000010;
    for (int k = 2; k <= 8; k++) begin
      tick();
      busy     = 1'b0;
      rd_ready = (k == 3);
      rd_data  = (k == 3) ? 16'h5A5A : 16'h0000;
      #1;
      if (p0_ack && ack_cyc < 0) begin ack_cyc = k; p0_req = 1'b0; end
    end
    rd_ready = 1'b0;
    checks++;
    if (ack_cyc != 4 || p0_rdata !== 16'h5A5A) begin
      failures++; $display("FAIL fast_read got=cyc%0d/%h exp=cyc4/5a5a", ack_cyc, p0_rdata);
    end
    // Hung controller: never busy, never rd_ready.
    pulses = 0; ack_cyc = -1;
    tick();
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 25'h0000020;
    for (int k = 2; k <= 30; k++) begin
      tick();
      busy = 1'b0; rd_ready = 1'b0; rd_data = 16'h1111;
      #1;
      if (rd_enable || wr_enable) pulses++;
      if (p0_ack && ack_cyc < 0) begin
        ack_cyc = k;
        p0_req = 1'b0;
        checks++;
        if (p0_err !== 1'b1) begin failures++; $display("FAIL to_err got=%b exp=1", p0_err); end
      end
    end
    checks++;
    if (ack_cyc != 22) begin failures++; $display("FAIL to_ack_cycle got=%0d exp=22", ack_cyc); end
    checks++;
    if (pulses != 1) begin failures++; $display("FAIL to_pulses got=%0d exp=1", pulses); end
    checks++;
    if (p0_rdata !== 16'h5A5A) begin failures++; $display("FAIL to_rdata got=%h exp=5a5a", p0_rdata); end
    // Next request is serviced normally.
    ack_cyc = -1; strobe_prev = 1'b0;
    tick();
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 25'h0000021; p0_wdata = 16'h2222;
    for (int k = 2; k <= 12; k++) begin
      tick();
      busy = strobe_prev;
      #1;
      strobe_prev = wr_enable;
      if (p0_ack && ack_cyc < 0) begin
        ack_cyc = k;
        p0_req = 1'b0;
        checks++;
        if (p0_err !== 1'b0) begin failures++; $display("FAIL post_to_err got=%b exp=0", p0_err); end
      end
    end
    busy = 1'b0;
    checks++;
    if (ack_cyc != 5) begin failures++; $display("FAIL post_to_ack_cycle got=%0d exp=5", ack_cyc); end
  endtask

  task automatic test_reset_mid_read();
    int ack_cyc;
    logic strobe_prev;
    ack_cyc = -1;
    tick();
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 25'h0000030;
    for (int k = 2; k <= 4; k++) begin
      tick();
      busy = (k >= 3);
    end
    tick();
    busy = 1'b1;
    #1;
    checks++;
    if (grant !== 2'b01) begin failures++; $display("FAIL pre_rst_grant got=%b exp=01", grant); end
    rst = 1'b1;
    p0_req = 1'b0;
    #1;
    checks++;
    if ({wr_enable, rd_enable, grant, p0_ack, p1_ack} !== 6'b000000) begin
      failures++; $display("FAIL rst_mid_outputs got=%b exp=000000", {wr_enable, rd_enable, grant, p0_ack, p1_ack});
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      #1;
      checks++;
      if (p0_ack || p1_ack || grant !== 2'b00) begin
        failures++; $display("FAIL rst_hold got=ack%b%b grant=%b exp=ack00 grant=00", p0_ack, p1_ack, grant);
      end
    end
    tick();
    rst = 1'b0; busy = 1'b0;
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 25'h0000040; p0_wdata = 16'h4444;
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 25'h0000050; p1_wdata = 16'h5555;
    tick();
    #1;
    checks++;
    if (grant !== 2'b01) begin failures++; $display("FAIL post_rst_tie got=%b exp=01", grant); end
    strobe_prev = wr_enable;
    for (int k = 3; k <= 12; k++) begin
      tick();
      busy = strobe_prev;
      #1;
      strobe_prev = wr_enable;
      if ((p0_ack || p1_ack) && ack_cyc < 0) begin
        ack_cyc = k;
        p0_req = 1'b0;
        p1_req = 1'b0;
        checks++;
        if (p0_ack !== 1'b1 || p1_ack !== 1'b0) begin
          failures++; $display("FAIL post_rst_ack got=%b%b exp=10", p0_ack, p1_ack);
        end
      end
    end
    busy = 1'b0;
    checks++;
    if (ack_cyc != 5) begin failures++; $display("FAIL post_rst_ack_cycle got=%0d exp=5", ack_cyc); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_round_robin();
    test_busy_stall();
    test_timeout();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Two-port arbiter and sequencer that shares the single `sdram_controller` instance between the CPU core's MEMR/MEMW path (port 0) and a secondary master such as a framebuffer-fill DMA engine (port 1). It serializes requests, drives the controller's read/write strobes as single-cycle pulses, tracks `busy`/`rd_ready` to detect completion, and returns a one-cycle acknowledge with read data to the granted requester. It also detects and reports a hung controller with a watchdog.

## Interface
Parameters:
- `ADDR_W`, default 25: SDRAM word address width.
- `DATA_W`, default 16: data width.
- `TIMEOUT`, default 255: maximum cycles to wait for completion before aborting. Valid range 1..65535.
- `FIXED_PRIORITY`, default 0: 0 selects round-robin arbitration; 1 makes port 0 always win.

Ports:
- `clk` in 1: the controller clock (`ram_clk` domain); all logic is on its rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `p0_req`, `p1_req` in 1: request. Hold high, with `pN_we`/`pN_addr`/`pN_wdata` stable, until `pN_ack`.
- `p0_we`, `p1_we` in 1: 1 selects write, 0 selects read.
- `p0_addr`, `p1_addr` in ADDR_W: word address.
- `p0_wdata`, `p1_wdata` in DATA_W: write data.
- `p0_ack`, `p1_ack` out 1: one-cycle completion pulse.
- `p0_err`, `p1_err` out 1: valid with ack. 1 means the access timed out.
- `p0_rdata`, `p1_rdata` out DATA_W: read data. Valid on the ack cycle and held until that port's next ack.
- `wr_addr` out ADDR_W, `wr_data` out DATA_W, `wr_enable` out 1: write side of the controller.
- `rd_addr` out ADDR_W, `rd_enable` out 1: read side of the controller.
- `rd_data` in DATA_W, `rd_ready` in 1, `busy` in 1: controller status.
- `grant` out 2: one-hot, identifies the port currently being serviced. 0 when idle.

## Operation
States: IDLE, ISSUE, WAIT_ACC, WAIT_DONE, RESP.

- **IDLE**
  - If no request is pending, stay in IDLE.
  - Otherwise select a winner:
    - Only one `pN_req` high: that port wins.
    - Both high, round-robin mode: the port not granted last wins.
    - Both high, `FIXED_PRIORITY=1`: port 0 wins.
  - Latch the winner's we/addr/wdata into internal registers, set `grant`, update `last_grant`, go to ISSUE.
- **ISSUE**
  - While `busy`=1, stay in ISSUE with no strobe.
  - When `busy`=0, pulse `wr_enable` (write) or `rd_enable` (read) for exactly one cycle, with addresses and data taken from the latched values. Go to WAIT_ACC.
- **WAIT_ACC**
  - `busy`=1: go to WAIT_DONE.
  - Read with `rd_ready`=1: capture `rd_data`, go to RESP. This covers fast completion.
- **WAIT_DONE**
  - Write: done when `busy` returns to 0.
  - Read: done when `rd_ready`=1. Capture `rd_data` into the granted port's rdata register on that cycle.
  - On done, go to RESP.
- **RESP**
  - Pulse `pN_ack` for the granted port, clear `grant`, go to IDLE.
- **Watchdog**
  - A 16-bit counter clears on entry to ISSUE and increments every cycle in ISSUE, WAIT_ACC and WAIT_DONE.
  - When the counter reaches `TIMEOUT`, go to RESP with `pN_err`=1. For a read, rdata is unchanged. The controller strobes are not re-issued.
- **Latched values:** the addr and data driven to the controller come from the latched copies only. Requester inputs may change after ack without affecting an access in flight.
- **Requests during service:** a `req` on the other port is ignored until IDLE. A `req` dropped mid-access does not abort it; the ack is still issued.
- **Back-to-back:** a port holding `req` high after its ack is treated as a new request in the next IDLE cycle.

## Timing
- Reset values:
  - All acks, errs, `wr_enable`, `rd_enable` = 0; `grant` = 0.
  - `wr_addr`, `rd_addr`, `wr_data`, `p0_rdata`, `p1_rdata` = 0.
  - State = IDLE; `last_grant` = port 1, so port 0 wins the first tie.
- Reset mid-access drops all strobes and returns to IDLE within the same cycle (asynchronous). No ack is issued.
- Minimum write latency, from req sampled in IDLE to ack, with `busy` high for one cycle: IDLE, ISSUE, WAIT_ACC, WAIT_DONE, RESP = ack in the 5th cycle.
- Read latency is 4 cycles plus the controller's `rd_ready` delay.
- Arbitration adds 1 idle cycle between consecutive accesses; there is no zero-bubble back-to-back.
- The strobe is never high for more than one cycle per access, and never asserted while `busy`=1.

## Test plan
- **Single write:** p0 write, addr 0x0001234, data 0xBEEF; model `busy` high for 3 cycles -> exactly one `wr_enable` pulse carrying 0x0001234/0xBEEF; then `p0_ack` with `p0_err`=0.
- **Single read:** p1 read, addr 0x00000FF; model returns 0xCAFE with `rd_ready` 6 cycles after the strobe -> `p1_ack` on the RESP cycle and `p1_rdata`=0xCAFE, held afterwards.
- **Round-robin tie:** both ports hold req continuously for 4 accesses -> grant order p0, p1, p0, p1. With `FIXED_PRIORITY=1` -> p0, p0, p0, p0.
- **Busy stall:** `busy` held high for 10 cycles when entering ISSUE -> no strobe during the stall; one strobe on the first cycle with `busy`=0.
- **Timeout:** `TIMEOUT`=20; model never asserts `rd_ready` -> `p0_ack` and `p0_err`=1 20 cycles after entering ISSUE; `p0_rdata` unchanged; the next request is serviced normally.
- **Reset mid-read:** assert `rst` in WAIT_DONE -> strobes 0, `grant`=0 and no ack in the same cycle; after release, the first tie goes to p0.
